// File: rtl/vga_tile_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_tile_timing
//  Description : Free-running 640x480@60 VGA timing generator for a 25 MHz
//                pixel clock. Produces registered sync pulses, the active-video
//                flag, tile column/row and in-tile pixel offsets, a frame
//                strobe and an optional game-speed tick.
//                Optional feature macro: VGA_MOVE_TICK_EN (enables the frame
//                counter and o_move_tick; when undefined o_move_tick is 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_tile_timing #(
    parameter int H_SYNC          = 92,
    parameter int H_BACK          = 50,
    parameter int H_DISPLAY       = 640,
    parameter int H_FRONT         = 18,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int V_DISPLAY       = 480,
    parameter int V_FRONT         = 10,
    parameter int TILE_SIZE       = 32,
    parameter int FRAMES_PER_TICK = 15
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    output logic       o_VGA_HSync,
    output logic       o_VGA_VSync,
    output logic [9:0] o_h_count,
    output logic [9:0] o_v_count,
    output logic       o_active,
    output logic [4:0] o_cell_x,
    output logic [3:0] o_cell_y,
    output logic [4:0] o_tile_px,
    output logic [4:0] o_tile_py,
    output logic       o_frame_start,
    output logic       o_move_tick
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISPLAY + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISPLAY + V_FRONT;

    // Counter boundaries; active windows are [start, end).
    localparam logic [9:0] c_h_last   = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_v_last   = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_h_sync   = 10'(H_SYNC);
    localparam logic [9:0] c_v_sync   = 10'(V_SYNC);
    localparam logic [9:0] c_h_start  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] c_h_end    = 10'(H_SYNC + H_BACK + H_DISPLAY);
    localparam logic [9:0] c_v_start  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] c_v_end    = 10'(V_SYNC + V_BACK + V_DISPLAY);
    localparam logic [4:0] c_tile_last = 5'(TILE_SIZE - 1);

    // Registered state; every output is a direct register copy.
    logic [9:0] r_h_count;
    logic [9:0] r_v_count;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_active;
    logic [4:0] r_cell_x;
    logic [3:0] r_cell_y;
    logic [4:0] r_tile_px;
    logic [4:0] r_tile_py;
    logic       r_frame_start;

    // Next-position decode. All outputs are computed from the position the
    // counters are about to take, so they line up with o_h_count/o_v_count.
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_h_last;
    logic       w_v_last;
    logic       w_frame_wrap;
    logic       w_h_act_next;
    logic       w_v_act_next;

    // Compute the next counter values and their decoded window flags.
    always_comb begin
        w_h_last     = (r_h_count == c_h_last);
        w_v_last     = (r_v_count == c_v_last);
        w_h_next     = w_h_last ? 10'd0 : (r_h_count + 10'd1);
        w_v_next     = r_v_count;
        if (w_h_last) begin
            w_v_next = w_v_last ? 10'd0 : (r_v_count + 10'd1);
        end
        w_frame_wrap = w_h_last & w_v_last;
        w_h_act_next = (w_h_next >= c_h_start) && (w_h_next < c_h_end);
        w_v_act_next = (w_v_next >= c_v_start) && (w_v_next < c_v_end);
    end

    // Position counters, syncs, active flag and frame strobe.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_h_count     <= 10'd0;
            r_v_count     <= 10'd0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_count     <= w_h_next;
            r_v_count     <= w_v_next;
            r_hsync       <= (w_h_next >= c_h_sync);
            r_vsync       <= (w_v_next >= c_v_sync);
            r_active      <= w_h_act_next & w_v_act_next;
            r_frame_start <= w_frame_wrap;
        end
    end

    // Horizontal tile sub-counters: offset rolls over into the column count,
    // both held at zero outside the horizontal active window.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_tile_px <= 5'd0;
            r_cell_x  <= 5'd0;
        end else if (!w_h_act_next || (w_h_next == c_h_start)) begin
            r_tile_px <= 5'd0;
            r_cell_x  <= 5'd0;
        end else if (r_tile_px == c_tile_last) begin
            r_tile_px <= 5'd0;
            r_cell_x  <= r_cell_x + 5'd1;
        end else begin
            r_tile_px <= r_tile_px + 5'd1;
        end
    end

    // Vertical tile sub-counters: advance only on line wrap so the row is
    // held through horizontal blanking.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_tile_py <= 5'd0;
            r_cell_y  <= 4'd0;
        end else if (w_h_last) begin
            if (!w_v_act_next || (w_v_next == c_v_start)) begin
                r_tile_py <= 5'd0;
                r_cell_y  <= 4'd0;
            end else if (r_tile_py == c_tile_last) begin
                r_tile_py <= 5'd0;
                r_cell_y  <= r_cell_y + 4'd1;
            end else begin
                r_tile_py <= r_tile_py + 5'd1;
            end
        end
    end

`ifdef VGA_MOVE_TICK_EN
    localparam logic [5:0] c_fpt_last = 6'(FRAMES_PER_TICK - 1);

    logic [5:0] r_frame_cnt;
    logic       r_move_tick;

    // Frame divider: the tick fires alongside the frame strobe that finds
    // the counter at its last value.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_frame_cnt <= 6'd0;
            r_move_tick <= 1'b0;
        end else begin
            r_move_tick <= 1'b0;
            if (w_frame_wrap) begin
                if (r_frame_cnt == c_fpt_last) begin
                    r_frame_cnt <= 6'd0;
                    r_move_tick <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 6'd1;
                end
            end
        end
    end

    assign o_move_tick = r_move_tick;
`else
    assign o_move_tick = 1'b0;
`endif

    assign o_VGA_HSync   = r_hsync;
    assign o_VGA_VSync   = r_vsync;
    assign o_h_count     = r_h_count;
    assign o_v_count     = r_v_count;
    assign o_active      = r_active;
    assign o_cell_x      = r_cell_x;
    assign o_cell_y      = r_cell_y;
    assign o_tile_px     = r_tile_px;
    assign o_tile_py     = r_tile_py;
    assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_tile_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_tile_timing
//  Description : Directed self-checking bench. A full-size instance covers
//                reset, sync edges and the horizontal tile sweep; a reduced
//                geometry instance (44x38, 8-pixel tiles, 3 frames per tick)
//                covers frame wrap, frame counts, ticks and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_tile_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_f_n = 1'b0;
    logic rst_s_n = 1'b0;

    // Full-size instance
    logic       f_hs, f_vs, f_act, f_fs, f_tick;
    logic [9:0] f_h, f_v;
    logic [4:0] f_cx, f_px, f_py;
    logic [3:0] f_cy;

    vga_tile_timing dut_full (
        .i_Clk(clk), .i_Reset_n(rst_f_n),
        .o_VGA_HSync(f_hs), .o_VGA_VSync(f_vs),
        .o_h_count(f_h), .o_v_count(f_v), .o_active(f_act),
        .o_cell_x(f_cx), .o_cell_y(f_cy), .o_tile_px(f_px), .o_tile_py(f_py),
        .o_frame_start(f_fs), .o_move_tick(f_tick)
    );

    // Reduced instance: H_TOTAL = 44 (active 8..39), V_TOTAL = 38 (active 4..35)
    localparam int S_HT = 44;
    localparam int S_FRAME = 44 * 38;
    logic       s_hs, s_vs, s_act, s_fs, s_tick;
    logic [9:0] s_h, s_v;
    logic [4:0] s_cx, s_px, s_py;
    logic [3:0] s_cy;

    vga_tile_timing #(
        .H_SYNC(4), .H_BACK(4), .H_DISPLAY(32), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(2), .V_DISPLAY(32), .V_FRONT(2),
        .TILE_SIZE(8), .FRAMES_PER_TICK(3)
    ) dut_small (
        .i_Clk(clk), .i_Reset_n(rst_s_n),
        .o_VGA_HSync(s_hs), .o_VGA_VSync(s_vs),
        .o_h_count(s_h), .o_v_count(s_v), .o_active(s_act),
        .o_cell_x(s_cx), .o_cell_y(s_cy), .o_tile_px(s_px), .o_tile_py(s_py),
        .o_frame_start(s_fs), .o_move_tick(s_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int f_pos = 0, s_pos = 0;
    int f_act_cnt = 0, f_fs_cnt = 0;
    int s_act_cnt = 0, s_fs_cnt = 0;
    int s_tick_wide = 0, s_tick_misalign = 0;
    int s_tick_mask = 0;
    logic s_tick_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: advance, sample 1 ns after the edge, update running tallies.
    task automatic step();
        logic rf, rs;
        rf = rst_f_n;
        rs = rst_s_n;
        @(posedge clk);
        #1;
        if (rf) f_pos++; else f_pos = 0;
        if (rs) s_pos++; else s_pos = 0;
        if (f_act) f_act_cnt++;
        if (f_fs)  f_fs_cnt++;
        if (rs) begin
            if (s_act) s_act_cnt++;
            if (s_fs) begin
                s_fs_cnt++;
                if (s_tick && s_fs_cnt < 31) s_tick_mask |= (1 << s_fs_cnt);
            end
            if (s_tick && !s_fs) s_tick_misalign++;
            if (s_tick && s_tick_prev) s_tick_wide++;
            s_tick_prev = s_tick;
        end
    endtask

    task automatic go_full(input int h, input int v);
        while (f_pos < v * 800 + h) step();
        check_eq("full_h_pos", 32'(f_h), 32'(h));
        check_eq("full_v_pos", 32'(f_v), 32'(v));
    endtask

    task automatic go_small(input int t);
        while (s_pos < t) step();
        check_eq("small_h_pos", 32'(s_h), 32'(t % S_HT));
        check_eq("small_v_pos", 32'((t / S_HT) % 38), 32'(s_v));
    endtask

    initial begin
        // ---------------- reset, full-size ----------------
        repeat (5) step();
        check_eq("rst_h", 32'(f_h), 0);
        check_eq("rst_v", 32'(f_v), 0);
        check_eq("rst_hs", 32'(f_hs), 0);
        check_eq("rst_vs", 32'(f_vs), 0);
        check_eq("rst_act", 32'(f_act), 0);
        check_eq("rst_fs", 32'(f_fs), 0);
        check_eq("rst_tick", 32'(f_tick), 0);
        rst_f_n = 1'b1;
        // first cycle after release still shows (0,0)
        check_eq("rel_h", 32'(f_h), 0);
        check_eq("rel_hs", 32'(f_hs), 0);

        // ---------------- line sweep, full-size ----------------
        go_full(91, 0);   check_eq("hs_low_91", 32'(f_hs), 0);
        go_full(92, 0);   check_eq("hs_rise_92", 32'(f_hs), 1);
        check_eq("vs_low_v0", 32'(f_vs), 0);
        go_full(0, 1);    check_eq("vs_low_v1", 32'(f_vs), 0);
                          check_eq("hs_low_h0", 32'(f_hs), 0);
        go_full(0, 2);    check_eq("vs_high_v2", 32'(f_vs), 1);
        go_full(142, 34); check_eq("act_v34", 32'(f_act), 0);
        go_full(141, 35); check_eq("act_h141", 32'(f_act), 0);
        go_full(142, 35);
        check_eq("act_h142", 32'(f_act), 1);
        check_eq("cx_h142", 32'(f_cx), 0);
        check_eq("px_h142", 32'(f_px), 0);
        check_eq("cy_v35", 32'(f_cy), 0);
        check_eq("py_v35", 32'(f_py), 0);
        go_full(173, 35); check_eq("cx_h173", 32'(f_cx), 0);
                          check_eq("px_h173", 32'(f_px), 31);
        go_full(174, 35); check_eq("cx_h174", 32'(f_cx), 1);
                          check_eq("px_h174", 32'(f_px), 0);
        go_full(781, 35);
        check_eq("cx_h781", 32'(f_cx), 19);
        check_eq("px_h781", 32'(f_px), 31);
        check_eq("act_h781", 32'(f_act), 1);
        go_full(782, 35);
        check_eq("act_h782", 32'(f_act), 0);
        check_eq("cx_h782", 32'(f_cx), 0);
        check_eq("px_h782", 32'(f_px), 0);
        go_full(0, 36);
        check_eq("py_v36", 32'(f_py), 1);
        check_eq("cy_v36", 32'(f_cy), 0);
        check_eq("full_active_line", 32'(f_act_cnt), 640);
        check_eq("full_no_fs", 32'(f_fs_cnt), 0);

        // ---------------- reduced geometry ----------------
        repeat (5) step();
        check_eq("s_rst_h", 32'(s_h), 0);
        check_eq("s_rst_vs", 32'(s_vs), 0);
        rst_s_n = 1'b1;
        go_small(35 * S_HT + 39);
        check_eq("s_cx_last", 32'(s_cx), 3);
        check_eq("s_px_last", 32'(s_px), 7);
        check_eq("s_cy_last", 32'(s_cy), 3);
        check_eq("s_py_last", 32'(s_py), 7);
        check_eq("s_act_last", 32'(s_act), 1);
        go_small(35 * S_HT + 40);
        check_eq("s_act_hend", 32'(s_act), 0);
        check_eq("s_cx_hend", 32'(s_cx), 0);
        check_eq("s_cy_hold", 32'(s_cy), 3);
        check_eq("s_py_hold", 32'(s_py), 7);
        go_small(36 * S_HT);
        check_eq("s_cy_vend", 32'(s_cy), 0);
        check_eq("s_py_vend", 32'(s_py), 0);
        go_small(S_FRAME - 1);
        check_eq("s_fs_before", 32'(s_fs), 0);
        go_small(S_FRAME);
        check_eq("s_fs_wrap", 32'(s_fs), 1);
        check_eq("s_active_frame", 32'(s_act_cnt), 1024);
        go_small(S_FRAME + 1);
        check_eq("s_fs_width", 32'(s_fs), 0);
        go_small(10 * S_FRAME);
        check_eq("s_fs_count", 32'(s_fs_cnt), 10);
`ifdef VGA_MOVE_TICK_EN
        check_eq("s_tick_frames", 32'(s_tick_mask), 32'((1 << 3) | (1 << 6) | (1 << 9)));
`else
        check_eq("s_tick_frames", 32'(s_tick_mask), 0);
`endif
        check_eq("s_tick_wide", 32'(s_tick_wide), 0);
        check_eq("s_tick_misalign", 32'(s_tick_misalign), 0);

        // ---------------- mid-frame reset ----------------
        go_small(10 * S_FRAME + 20 * S_HT + 20);
        check_eq("mid_pre_act", 32'(s_act), 1);
        s_fs_cnt = 0;
        rst_s_n = 1'b0;
        step();
        check_eq("mid_h", 32'(s_h), 0);
        check_eq("mid_v", 32'(s_v), 0);
        check_eq("mid_hs", 32'(s_hs), 0);
        check_eq("mid_vs", 32'(s_vs), 0);
        check_eq("mid_act", 32'(s_act), 0);
        check_eq("mid_cx", 32'(s_cx), 0);
        check_eq("mid_cy", 32'(s_cy), 0);
        check_eq("mid_px", 32'(s_px), 0);
        check_eq("mid_py", 32'(s_py), 0);
        check_eq("mid_fs", 32'(s_fs), 0);
        check_eq("mid_tick", 32'(s_tick), 0);
        rst_s_n = 1'b1;
        go_small(3);
        check_eq("mid_hs_3", 32'(s_hs), 0);
        go_small(4);
        check_eq("mid_hs_4", 32'(s_hs), 1);
        go_small(S_FRAME);
        check_eq("mid_fs_restart", 32'(s_fs), 1);
        check_eq("mid_fs_count", 32'(s_fs_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected completion before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
